// File: rtl/uart_rx.sv
// uart_rx: UART receiver that synchronises the line, samples each bit at mid-bit and assembles LSB-first words.
// Define UART_RX_PARITY_EN to add an even-parity bit before the stop bit and the parity_err_o output.
`ifndef UART_DATA_WIDTH
`define UART_DATA_WIDTH 8
`endif
module uart_rx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        serial_i,
    output logic [`UART_DATA_WIDTH-1:0] data_o,
    output logic                        data_v_o,
    output logic                        frame_err_o,
`ifdef UART_RX_PARITY_EN
    output logic                        parity_err_o,
`endif
    output logic                        busy_o
);
    localparam int DW = `UART_DATA_WIDTH;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0] LAST_BIT = 3'(DW - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [DW-1:0]          shift_q, shift_d;
    logic [DW-1:0]          data_q, data_d;
    logic                   data_v_q, data_v_d;
    logic                   frame_err_q, frame_err_d;
    logic                   s_line, half, last, stop_ok, word_ok;
`ifdef UART_RX_PARITY_EN
    logic                   parity_q, parity_d;
    logic                   parity_err_q, parity_err_d;
`endif

    assign s_line = sync_q[SYNC_STAGES-1];
    assign half   = timer_q == T_HALF;
    assign last   = timer_q == T_LAST;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            sync_q       <= '1;
            timer_q      <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            data_v_q     <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_q     <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            timer_q      <= timer_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            data_v_q     <= data_v_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            parity_q     <= parity_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = s_line ? IDLE : START;
            START:   if (half) state_d = s_line ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:    if (last && bit_idx_q == LAST_BIT) state_d = PARITY;
            PARITY:  if (last) state_d = STOP;
`else
            DATA:    if (last && bit_idx_q == LAST_BIT) state_d = STOP;
`endif
            STOP:    if (last) state_d = s_line ? IDLE : BREAK;
            BREAK:   if (s_line) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], serial_i};
        timer_d   = (state_q == IDLE || state_q == BREAK || last || (state_q == START && half)) ? '0 : timer_q + 1'b1;
        bit_idx_d = (state_q == START && half) ? '0 : (state_q == DATA && last) ? bit_idx_q + 1'b1 : bit_idx_q;
        shift_d   = (state_q == DATA && last) ? {s_line, shift_q[DW-1:1]} : shift_q;
        stop_ok   = state_q == STOP && last && s_line;
`ifdef UART_RX_PARITY_EN
        parity_d     = (state_q == PARITY && last) ? s_line : parity_q;
        word_ok      = stop_ok && !(^shift_q ^ parity_q);
        parity_err_d = stop_ok && (^shift_q ^ parity_q);
`else
        word_ok      = stop_ok;
`endif
        data_d      = word_ok ? shift_q : data_q;
        data_v_d    = word_ok;
        frame_err_d = state_q == STOP && last && !s_line;
    end

    assign data_o      = data_q;
    assign data_v_o    = data_v_q;
    assign frame_err_o = frame_err_q;
    assign busy_o      = state_q != IDLE;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = parity_err_q;
`endif
endmodule
